pcie_app_consumer_ctrl: RTL and testbench

Rate-throttled consumer and checksum controller for the demo app's CPU->FPGA stream. Sits between tlp_xcvr's CPU register channel and its inbound data stream. Paces the stream's ready signal from the CONSUMER_RATE register. Accumulates a 64-bit checksum of accepted beats, exposed through CHECKSUM_MSW/CHECKSUM_LSW.

---
 rtl/pcie_app_consumer_ctrl.sv | 138 +++++++++++++
 tb/tb_pcie_app_consumer_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_app_consumer_ctrl.sv
// Rate-throttled consumer of the CPU->FPGA stream, with a 64-bit checksum of accepted beats behind atomic LSW/MSW reads.
// Latency: register reads return one cycle after cpuRdValid_in; a beat is summed in its accept cycle and readable the next cycle.
// Backpressure: rxReady_out paced by CONSUMER_RATE (0 = always ready); optional stall counter under PCIE_APP_STALL_COUNT_EN.
module pcie_app_consumer_ctrl #(
    parameter int ADDR_W   = 6,
    // Mirrors the transceiver's control block base; the app registers sit just below it.
    parameter int CTL_BASE = 32
) (
    input  logic              pcieClk_in,
    input  logic              pcieRst_in,
    input  logic [ADDR_W-1:0] cpuWrAddr_in,
    input  logic [31:0]       cpuWrData_in,
    input  logic              cpuWrValid_in,
    input  logic [ADDR_W-1:0] cpuRdAddr_in,
    input  logic              cpuRdValid_in,
    output logic [31:0]       cpuRdData_out,
    input  logic [63:0]       rxData_in,
    input  logic              rxValid_in,
    output logic              rxReady_out
);

    localparam logic [ADDR_W-1:0] ADDR_MSW   = ADDR_W'(CTL_BASE - 1);
    localparam logic [ADDR_W-1:0] ADDR_LSW   = ADDR_W'(CTL_BASE - 2);
    localparam logic [ADDR_W-1:0] ADDR_RATE  = ADDR_W'(CTL_BASE - 3);
    localparam logic [ADDR_W-1:0] ADDR_STALL = ADDR_W'(CTL_BASE - 4);

    logic [7:0]  rate;
    logic [7:0]  phase;
    logic        token;
    logic [63:0] checksum;
    logic [31:0] msb_shadow;
    logic [31:0] rd_data;
    logic [31:0] rd_mux;
    logic [31:0] stall_rd;
    logic [8:0]  phase_sum;
    logic        rx_ready;
    logic        accept;
    logic        wr_rate;
    logic        wr_sum_clr;
    logic        rd_lsw;

    // Only the low byte of write data is meaningful to any register here.
    logic        unused_wr_bits;
    assign unused_wr_bits = ^cpuWrData_in[31:8];

    // Ready is forced low during reset so a beat in the reset cycle is never taken.
    assign rx_ready   = !pcieRst_in && ((rate == 8'd0) || token);
    assign accept     = rxValid_in && rx_ready;
    assign phase_sum  = {1'b0, phase} + {1'b0, rate};
    assign wr_rate    = cpuWrValid_in && (cpuWrAddr_in == ADDR_RATE);
    assign wr_sum_clr = cpuWrValid_in && ((cpuWrAddr_in == ADDR_LSW) || (cpuWrAddr_in == ADDR_MSW));
    assign rd_lsw     = cpuRdValid_in && (cpuRdAddr_in == ADDR_LSW);

    assign rxReady_out   = rx_ready;
    assign cpuRdData_out = rd_data;

    // Pacing: phase accumulator carry grants a single token; a new rate restarts pacing from scratch.
    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            rate  <= 8'd0;
            phase <= 8'd0;
            token <= 1'b0;
        end else if (wr_rate) begin
            rate  <= cpuWrData_in[7:0];
            phase <= 8'd0;
            token <= 1'b0;
        end else begin
            phase <= phase_sum[7:0];
            if (phase_sum[8]) begin
                token <= 1'b1;
            end else if (accept) begin
                token <= 1'b0;
            end
        end
    end

    // Checksum accumulation; a write to either half clears it and beats the concurrent accept.
    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            checksum   <= 64'd0;
            msb_shadow <= 32'd0;
        end else if (wr_sum_clr) begin
            checksum   <= 64'd0;
            msb_shadow <= 32'd0;
        end else begin
            if (accept) begin
                checksum <= checksum + rxData_in;
            end
            // Freeze the upper half at LSW-read time so the later MSW read is coherent.
            if (rd_lsw) begin
                msb_shadow <= checksum[63:32];
            end
        end
    end

`ifdef PCIE_APP_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    // Saturating count of cycles where the stream offered data but was held off.
    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            stall_cnt <= 32'd0;
        end else if (cpuWrValid_in && (cpuWrAddr_in == ADDR_STALL)) begin
            stall_cnt <= 32'd0;
        end else if (rxValid_in && !rx_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_rd = stall_cnt;
`else
    assign stall_rd = 32'd0;
`endif

    // Read decode against pre-write state; unmapped addresses read zero.
    always_comb begin
        rd_mux = 32'd0;
        if (cpuRdAddr_in == ADDR_LSW) begin
            rd_mux = checksum[31:0];
        end else if (cpuRdAddr_in == ADDR_MSW) begin
            rd_mux = msb_shadow;
        end else if (cpuRdAddr_in == ADDR_RATE) begin
            rd_mux = {24'd0, rate};
        end else if (cpuRdAddr_in == ADDR_STALL) begin
            rd_mux = stall_rd;
        end
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge pcieClk_in) begin
        if (pcieRst_in) begin
            rd_data <= 32'd0;
        end else if (cpuRdValid_in) begin
            rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pcie_app_consumer_ctrl.sv
// Bench for pcie_app_consumer_ctrl: directed scenarios plus randomized traffic against a reference model.
// The model derives token grants from floor(k*R/256) counting since the last rate change.
// Ready and read data are compared every cycle at the falling edge.
module tb_pcie_app_consumer_ctrl;

    localparam int ADDR_W   = 6;
    localparam int CTL_BASE = 32;
    localparam logic [5:0] A_MSW   = 6'(CTL_BASE - 1);
    localparam logic [5:0] A_LSW   = 6'(CTL_BASE - 2);
    localparam logic [5:0] A_RATE  = 6'(CTL_BASE - 3);
    localparam logic [5:0] A_STALL = 6'(CTL_BASE - 4);

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [5:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        wv = 1'b0;
    logic [5:0]  ra = '0;
    logic        rv = 1'b0;
    logic [63:0] rxd = '0;
    logic        rxv = 1'b0;
    logic [31:0] rdo;
    logic        rdy;

    pcie_app_consumer_ctrl #(.ADDR_W(ADDR_W), .CTL_BASE(CTL_BASE)) dut (
        .pcieClk_in    (clk),
        .pcieRst_in    (rst),
        .cpuWrAddr_in  (wa),
        .cpuWrData_in  (wd),
        .cpuWrValid_in (wv),
        .cpuRdAddr_in  (ra),
        .cpuRdValid_in (rv),
        .cpuRdData_out (rdo),
        .rxData_in     (rxd),
        .rxValid_in    (rxv),
        .rxReady_out   (rdy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]      m_rate;
    longint unsigned m_k;
    bit              m_token;
    logic [63:0]     m_sum;
    logic [31:0]     m_shadow;
    logic [31:0]     m_rd;
    logic [31:0]     m_stall;

    int cyc     = 0;
    bit obs_rdy = 1'b0;
    bit obs_acc = 1'b0;

    task automatic model_reset();
        m_rate   = 8'd0;
        m_k      = 0;
        m_token  = 1'b0;
        m_sum    = 64'd0;
        m_shadow = 32'd0;
        m_rd     = 32'd0;
        m_stall  = 32'd0;
    endtask

    task automatic model_step(input bit rdy_m);
        logic [31:0] rd_n;
        bit          acc;
        bit          carry;
        if (rst) begin
            model_reset();
            return;
        end
        acc  = rxv && rdy_m;
        rd_n = m_rd;
        if (rv) begin
            rd_n = 32'd0;
            if (ra == A_LSW)       rd_n = m_sum[31:0];
            else if (ra == A_MSW)  rd_n = m_shadow;
            else if (ra == A_RATE) rd_n = {24'd0, m_rate};
`ifdef PCIE_APP_STALL_COUNT_EN
            else if (ra == A_STALL) rd_n = m_stall;
`endif
        end
`ifdef PCIE_APP_STALL_COUNT_EN
        if (wv && wa == A_STALL) m_stall = 32'd0;
        else if (rxv && !rdy_m && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
`endif
        if (wv && wa == A_RATE) begin
            m_rate  = wd[7:0];
            m_k     = 0;
            m_token = 1'b0;
        end else begin
            m_k     = m_k + 1;
            carry   = ((m_k * m_rate) >> 8) != (((m_k - 1) * m_rate) >> 8);
            m_token = carry || (m_token && !acc);
        end
        if (wv && (wa == A_LSW || wa == A_MSW)) begin
            m_sum    = 64'd0;
            m_shadow = 32'd0;
        end else begin
            if (rv && ra == A_LSW) m_shadow = m_sum[63:32];
            if (acc) m_sum = m_sum + rxd;
        end
        m_rd = rd_n;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        bit rdy_m;
        @(negedge clk);
        rdy_m   = rst ? 1'b0 : ((m_rate == 8'd0) || m_token);
        obs_rdy = rdy;
        obs_acc = !rst && rxv && rdy;
        check("ready", {63'd0, rdy}, {63'd0, rdy_m});
        check("rddata", {32'd0, rdo}, {32'd0, m_rd});
        @(posedge clk);
        model_step(rdy_m);
        cyc++;
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        wv = 1'b1; wa = a; wd = d;
        cycle();
        wv = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        rv = 1'b1; ra = a;
        cycle();
        rv = 1'b0;
        d = rdo;
    endtask

    function automatic logic [5:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return A_MSW;
            1: return A_LSW;
            2: return A_RATE;
            3: return A_STALL;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int cnt;
        int last;
        int min_gap;
        model_reset();

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        check("rst_ready_low", {63'd0, obs_rdy}, 64'd0);
        check("rst_rddata", {32'd0, rdo}, 64'd0);
        rst = 1'b0;

        // Full speed, 100 beats of 1
        rxv = 1'b1; rxd = 64'd1; cnt = 0;
        repeat (100) begin
            cycle();
            if (obs_acc) cnt++;
        end
        rxv = 1'b0;
        check("fs_beats", 64'(cnt), 64'd100);
        rd(A_LSW, d); check("fs_lsw", {32'd0, d}, 64'd100);
        rd(A_MSW, d); check("fs_msw", {32'd0, d}, 64'd0);

        // Rate 64 over 1024 cycles
        wr(A_RATE, 32'hFFFF_FF40);
        rd(A_RATE, d); check("rate_readback", {32'd0, d}, 64'd64);
        rxv = 1'b1; cnt = 0; last = -1; min_gap = 1 << 30;
        for (int i = 0; i < 1024; i++) begin
            rxd = {$urandom, $urandom};
            cycle();
            if (obs_acc) begin
                cnt++;
                if (last >= 0 && (cyc - last) < min_gap) min_gap = cyc - last;
                last = cyc;
            end
        end
        rxv = 1'b0;
        check("r64_beats_255_to_257", {63'd0, (cnt >= 255 && cnt <= 257)}, 64'd1);
        check("r64_min_gap_ge4", {63'd0, (min_gap >= 4)}, 64'd1);

        // Checksum wrap
        wr(A_RATE, 32'd0);
        wr(A_LSW, $urandom);
        rxv = 1'b1; rxd = 64'hFFFF_FFFF_FFFF_FFFF; cycle();
        rxd = 64'd2; cycle();
        rxv = 1'b0;
        rd(A_LSW, d); check("wrap_lsw", {32'd0, d}, 64'd1);
        rd(A_MSW, d); check("wrap_msw", {32'd0, d}, 64'd0);
        wr(A_MSW, $urandom);
        rxv = 1'b1; rxd = 64'h0000_0001_FFFF_FFFF; cycle();
        rxd = 64'd1; cycle();
        rxv = 1'b0;
        rd(A_LSW, d); check("atomic_lsw", {32'd0, d}, 64'd0);
        rxv = 1'b1; rxd = 64'h0000_0001_0000_0000; cycle();
        rxv = 1'b0;
        rd(A_MSW, d); check("atomic_msw_shadow", {32'd0, d}, 64'd2);

        // Clear races an accepted beat
        rxv = 1'b1; rxd = 64'h55; wv = 1'b1; wa = A_LSW; wd = $urandom;
        cycle();
        wv = 1'b0; rxv = 1'b0;
        rd(A_LSW, d); check("clr_race_lsw", {32'd0, d}, 64'd0);
        rd(A_MSW, d); check("clr_race_msw", {32'd0, d}, 64'd0);

        // Mid-stream reset at rate 16
        wr(A_RATE, 32'd16);
        rxv = 1'b1;
        repeat (40) begin
            rxd = {$urandom, $urandom};
            cycle();
        end
        rst = 1'b1; cycle();
        check("midrst_ready_low", {63'd0, obs_rdy}, 64'd0);
        rst = 1'b0; rxd = 64'd0; cycle();
        check("midrst_resume_ready", {63'd0, obs_rdy}, 64'd1);
        rxv = 1'b0;
        rd(A_LSW, d);  check("midrst_lsw", {32'd0, d}, 64'd0);
        rd(A_MSW, d);  check("midrst_msw", {32'd0, d}, 64'd0);
        rd(A_RATE, d); check("midrst_rate", {32'd0, d}, 64'd0);
        rd(6'd63, d);  check("unmapped_rd", {32'd0, d}, 64'd0);

        // Stall counter
        wr(A_STALL, 32'd0);
        wr(A_RATE, 32'd128);
        rxv = 1'b1;
        repeat (256) begin
            rxd = {$urandom, $urandom};
            cycle();
        end
        rxv = 1'b0;
        rd(A_STALL, d);
`ifdef PCIE_APP_STALL_COUNT_EN
        check("stall_127_to_129", {63'd0, (d >= 32'd127 && d <= 32'd129)}, 64'd1);
`else
        check("stall_absent_reads0", {32'd0, d}, 64'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            rxv = ($urandom_range(0, 3) != 0);
            rxd = {$urandom, $urandom};
            wv  = ($urandom_range(0, 19) == 0);
            wa  = pick_addr();
            wd  = $urandom;
            rv  = ($urandom_range(0, 2) == 0);
            ra  = pick_addr();
            cycle();
        end
        rst = 1'b0; wv = 1'b0; rv = 1'b0; rxv = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
